// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the blocks it brings out of reset.
// master is the sequencer side; slave is the side of the stage owners and the lock source.
interface reset_sequencer_if #(
  parameter int N_STAGES = 4
);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  logic                pll_locked;
  logic [N_STAGES-1:0] stage_ready;
  logic                sw_reset_req;
  logic [N_STAGES-1:0] stage_rst_n;
  logic                seq_done;
  logic                fault;
  logic [IDX_W-1:0]    fault_stage;

  modport master (
    input  pll_locked, stage_ready, sw_reset_req,
    output stage_rst_n, seq_done, fault, fault_stage
  );

  modport slave (
    output pll_locked, stage_ready, sw_reset_req,
    input  stage_rst_n, seq_done, fault, fault_stage
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases N_STAGES reset domains in index order once PLL lock has been stable,
// waiting a hold gap and a per-stage ready ack between releases.
module reset_sequencer #(
  parameter int N_STAGES    = 4,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  reset_sequencer_if.master  bus
);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int MAX_A = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int MAX_C = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    HOLD,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  state_t              r_state;
  logic                r_lock_m;
  logic                r_lock_s;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [N_STAGES-1:0] r_stage_rst_n;
  logic                r_seq_done;
  logic                r_fault;
  logic [IDX_W-1:0]    r_fault_stage;

  logic w_lock_lost;
  logic w_restart;
  logic w_ack;
  logic w_last;

  // Lock loss only matters once sequencing has begun; FAULT deliberately ignores it.
  assign w_lock_lost = !r_lock_s &&
                       (r_state == HOLD || r_state == WAIT_ACK || r_state == DONE);
  assign w_restart   = bus.sw_reset_req || w_lock_lost;
  assign w_ack       = bus.stage_ready[r_idx];
  assign w_last      = (r_idx == IDX_W'(N_STAGES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= WAIT_LOCK;
      r_lock_m      <= 1'b0;
      r_lock_s      <= 1'b0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_stage_rst_n <= '0;
      r_seq_done    <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_stage <= '0;
    end else begin
      r_lock_m <= bus.pll_locked;
      r_lock_s <= r_lock_m;
      if (w_restart) begin
        r_state       <= WAIT_LOCK;
        r_cnt         <= '0;
        r_idx         <= '0;
        r_stage_rst_n <= '0;
        r_seq_done    <= 1'b0;
        if (bus.sw_reset_req) begin
          r_fault       <= 1'b0;
          r_fault_stage <= '0;
        end
      end else begin
        case (r_state)
          WAIT_LOCK: begin
            if (!r_lock_s) begin
              r_cnt <= '0;
            end else if (r_cnt == CNT_W'(LOCK_FILTER - 1)) begin
              r_cnt   <= '0;
              r_state <= HOLD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          HOLD: begin
            if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              r_stage_rst_n[r_idx] <= 1'b1;
              r_cnt                <= '0;
              r_state              <= WAIT_ACK;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          WAIT_ACK: begin
            // An ack on the timeout edge still counts as an ack.
            if (w_ack) begin
              r_cnt <= '0;
              if (w_last) begin
                r_seq_done <= 1'b1;
                r_state    <= DONE;
              end else begin
                r_idx   <= r_idx + IDX_W'(1);
                r_state <= HOLD;
              end
            end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
              r_fault       <= 1'b1;
              r_fault_stage <= r_idx;
              r_stage_rst_n <= '0;
              r_cnt         <= '0;
              r_state       <= FAULT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          DONE: begin
            r_stage_rst_n <= '1;
            r_seq_done    <= 1'b1;
          end
          FAULT: begin
            r_stage_rst_n <= '0;
            r_seq_done    <= 1'b0;
            r_fault       <= 1'b1;
          end
          default: r_state <= WAIT_LOCK;
        endcase
      end
    end
  end

  assign bus.stage_rst_n = r_stage_rst_n;
  assign bus.seq_done    = r_seq_done;
  assign bus.fault       = r_fault;
  assign bus.fault_stage = r_fault_stage;
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the synchronous reset bridge and consumes its active-low synchronized reset as `rst_n`.
- Waits for a stable PLL lock, then releases `N_STAGES` downstream reset domains one at a time, in index order.
- A programmable hold gap separates each release.
- Each stage must acknowledge readiness before the next stage is released.
- Lock loss, a software reset request or an ack timeout re-asserts every stage reset.

Parameters:
- N_STAGES, 4: number of sequenced reset outputs (≥1).
- LOCK_FILTER, 8: consecutive synchronized-lock cycles required before sequencing starts (≥1).
- HOLD_CYCLES, 16: cycles from entering HOLD to releasing the current stage (≥1).
- ACK_TIMEOUT, 1024: maximum cycles in WAIT_ACK before FAULT (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset; the codebase drives it from the bridge's sync_rst_n_out.
- pll_locked  in  1  asynchronous PLL lock; synchronized internally with 2 flops.
- stage_ready  in  N_STAGES  per-stage ready ack; synchronous to clk.
- sw_reset_req  in  1  synchronous single-cycle restart request.
- stage_rst_n  out  N_STAGES  registered active-low stage resets.
- seq_done  out  1  all stages released and acked.
- fault  out  1  sticky ack-timeout flag.
- fault_stage  out  max(1,$clog2(N_STAGES))  index of the stage that timed out.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: stage_rst_n all 0, seq_done 0, fault 0, fault_stage 0.
  - Internal: state WAIT_LOCK, index 0, all counters 0, both sync flops 0.
- Lock synchronizer: lock_s is pll_locked delayed 2 edges. Edge 1 samples pll_locked; lock_s is visible after edge 2.
- States: WAIT_LOCK, HOLD, WAIT_ACK, DONE, FAULT. All outputs are registered.
- WAIT_LOCK:
  - The filter counter increments on each edge that samples lock_s=1 and clears on lock_s=0.
  - Transition to HOLD occurs at the edge where lock_s=1 and count==LOCK_FILTER-1 (LOCK_FILTER consecutive high samples).
- HOLD:
  - The hold counter counts HOLD_CYCLES edges after entry.
  - On the final edge: stage_rst_n[idx] is set to 1, state goes to WAIT_ACK, and the timeout counter clears.
- WAIT_ACK:
  - If the edge samples stage_ready[idx]=1 and idx==N_STAGES-1: seq_done is set to 1 at that edge and state goes to DONE.
  - If the edge samples stage_ready[idx]=1 otherwise: idx increments and state goes to HOLD.
  - With no ack sampled on edges 1..ACK_TIMEOUT after entry: at edge ACK_TIMEOUT, fault is set to 1, fault_stage is set to idx, all stage_rst_n are set to 0, and state goes to FAULT.
  - An ack sampled on the timeout edge wins over the timeout.
  - Acks from already-released stages are ignored; they may drop without effect.
- DONE: holds all stage_rst_n at 1 and seq_done at 1.
- FAULT:
  - Holds all stage_rst_n at 0, fault at 1 and seq_done at 0.
  - lock_s is ignored.
  - Exit only via sw_reset_req or rst_n.
- Restart action:
  - Effects: all stage_rst_n set to 0, seq_done set to 0, idx set to 0, counters cleared, state goes to WAIT_LOCK.
  - Trigger 1: sw_reset_req=1 sampled in any state. This also clears fault and fault_stage.
  - Trigger 2: lock_s=0 sampled in HOLD, WAIT_ACK or DONE. fault is not affected.
- Priority at one edge, highest first: sw_reset_req, lock loss, ack, timeout, hold/filter count.
- Invariant: a stage is never released while any lower-indexed stage reset is 0.
- Invariant: stage_rst_n is always a contiguous run of 1s from bit 0.

Test Plan:
- Nominal: rst_n high, pll_locked rises, all stage_ready tied 1 → stage_rst_n[0] rises at edge 26 (2+8+16) after the first edge sampling lock. Bits 1,2,3 rise at edges 43, 60, 77. seq_done rises at edge 78.
- Ack gating: stage_ready[1] held 0 for 500 cycles after stage 1 is released, then asserted → stage_rst_n[2] stays 0 until 16 edges after the ack edge. No fault.
- Timeout: stage_ready[2] never asserted → fault=1 and fault_stage=2 at edge 1024 after entering WAIT_ACK; stage_rst_n=4'b0000. A later pll_locked toggle changes nothing.
- Ack on timeout edge: stage_ready[0] first asserted on edge 1024 of WAIT_ACK → no fault; sequencing continues to HOLD for stage 1.
- Lock loss in DONE: pll_locked drops at edge j → stage_rst_n=4'b0000 and seq_done=0 at edge j+2. Relock repeats the nominal timing.
- Glitch and restart:
  - pll_locked high for 5 cycles then low → no release.
  - sw_reset_req pulsed during FAULT → fault=0 at the same edge; the nominal sequence follows.
  - rst_n pulsed low mid-HOLD → outputs reset immediately, without waiting for a clock edge.
